// File: rtl/line_serializer_tx.sv
// line_serializer_tx
// Accepts whole cache lines on an upstream valid/ready port and emits them
// one word at a time, lowest word first, on a downstream valid/ready port.
// An active line register plus a pending (skid) line register let lines
// stream back to back with no bubble while keeping ready_out registered.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   valid_in   upstream line valid
//   ready_out  upstream ready (low while a pending line is held)
//   line_in    upstream line, word k at [k*WORD_BITS +: WORD_BITS]
//   valid_out  downstream word valid
//   ready_in   downstream ready
//   word_out   current word of the active line
//   word_idx   index of the current word
//   last_out   current word is the last of its line
//   busy       any line held (active or pending)
module line_serializer_tx #(
    parameter int WORD_BITS      = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINE_BITS      = WORD_BITS * WORDS_PER_LINE,
    parameter int IDX_BITS       = $clog2(WORDS_PER_LINE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [LINE_BITS-1:0] line_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [WORD_BITS-1:0] word_out,
    output logic [IDX_BITS-1:0]  word_idx,
    output logic                 last_out,
    output logic                 busy
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS_PER_LINE - 1);

    logic [LINE_BITS-1:0] active_line_q,  active_line_d;
    logic                 active_valid_q, active_valid_d;
    logic [LINE_BITS-1:0] pending_line_q, pending_line_d;
    logic                 pending_valid_q, pending_valid_d;
    logic [IDX_BITS-1:0]  cnt_q,          cnt_d;

    logic                 acc_s;
    logic                 snd_s;
    logic                 fin_s;
    logic                 last_s;
    logic [WORD_BITS-1:0] line_words_s [WORDS_PER_LINE];

    // Split the active line into an addressable array of words.
    always_comb begin
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            line_words_s[k] = active_line_q[k*WORD_BITS +: WORD_BITS];
        end
    end

    assign last_s    = (cnt_q == LAST_IDX);
    assign acc_s     = valid_in & ~pending_valid_q;
    assign snd_s     = active_valid_q & ready_in;
    assign fin_s     = snd_s & last_s;

    assign ready_out = ~pending_valid_q;
    assign valid_out = active_valid_q;
    assign word_out  = line_words_s[cnt_q];
    assign word_idx  = cnt_q;
    assign last_out  = last_s;
    assign busy      = active_valid_q | pending_valid_q;

    // Next-state: word counter advance plus line movement between registers.
    always_comb begin
        active_line_d   = active_line_q;
        active_valid_d  = active_valid_q;
        pending_line_d  = pending_line_q;
        pending_valid_d = pending_valid_q;
        cnt_d           = cnt_q;

        // Counter moves within a line; fin and empty-load handled below.
        if (snd_s && !last_s) begin
            cnt_d = cnt_q + IDX_BITS'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (fin_s) begin
            cnt_d = '0;
            if (pending_valid_q) begin
                // Pending always wins: it was accepted earlier than line_in,
                // and acc cannot be high while pending is held anyway.
                active_line_d   = pending_line_q;
                pending_valid_d = 1'b0;
            end else if (acc_s) begin
                // Same-cycle accept and finish: load straight into active.
                active_line_d = line_in;
            end else begin
                active_valid_d = 1'b0;
            end
        end else if (acc_s) begin
            if (!active_valid_q) begin
                active_line_d  = line_in;
                active_valid_d = 1'b1;
                cnt_d          = '0;
            end else begin
                pending_line_d  = line_in;
                pending_valid_d = 1'b1;
            end
        end else begin
            active_valid_d  = active_valid_q;
            pending_valid_d = pending_valid_q;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_valid_q  <= 1'b0;
            pending_valid_q <= 1'b0;
            cnt_q           <= '0;
        end else begin
            active_valid_q  <= active_valid_d;
            pending_valid_q <= pending_valid_d;
            cnt_q           <= cnt_d;
        end
    end

    // Line data registers; contents are meaningless while their valid is low.
    always_ff @(posedge clk) begin
        active_line_q  <= active_line_d;
        pending_line_q <= pending_line_d;
    end

endmodule
